// File: rtl/accel_stream_pkg.sv
// Shared defaults and helpers for the accelerator stream endpoint.
package accel_stream_pkg;

  localparam int unsigned DEF_DW             = 128;
  localparam int unsigned DEF_PTR_W          = 10;
  localparam int unsigned DEF_IN_DEPTH_LOG2  = 9;
  localparam int unsigned DEF_OUT_DEPTH_LOG2 = 4;

  // Occupancy needs one more bit than the index so that "full" is representable.
  function automatic int unsigned occ_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/accel_stream_if.sv
// Valid/ready stream bundle; master drives data/valid, slave drives ready.
interface accel_stream_if
  import accel_stream_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);

  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO: registered memory read feeding an
// output register that is counted in the occupancy.
module stream_fifo
  import accel_stream_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DW-1:0]                  in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DW-1:0]                  out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [occ_w(DEPTH_LOG2)-1:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = occ_w(DEPTH_LOG2);
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_c;
  logic          pop_c;
  logic          load_c;
  logic          mem_empty_c;
  logic [LW-1:0] level_next_c;

  assign push_c      = in_valid && in_ready;
  assign pop_c       = out_valid && out_ready;
  assign mem_empty_c = (wr_ptr == rd_ptr);
  // Refill the output register whenever it is free or being drained this edge.
  assign load_c      = !mem_empty_c && (!out_valid || pop_c);

  always_comb begin
    level_next_c = level;
    if (push_c && !pop_c) begin
      level_next_c = level + LW'(1);
    end else if (!push_c && pop_c) begin
      level_next_c = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      level     <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load_c) begin
        rd_ptr    <= rd_ptr + PW'(1);
        out_valid <= 1'b1;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end
      level    <= level_next_c;
      in_ready <= (level_next_c != LW'(DEPTH));
    end
  end

  // Storage and read register carry no reset; valid qualifies them.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
    if (load_c) begin
      out_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: rtl/accel_stream_endpoint.sv
// Accelerator-side terminus of the toaccel/fromaccel stream pair: inbound and
// outbound FIFOs plus the progress counters used for host-side flow control.
module accel_stream_endpoint
  import accel_stream_pkg::*;
#(
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned PTR_W          = DEF_PTR_W,
  parameter int unsigned IN_DEPTH_LOG2  = DEF_IN_DEPTH_LOG2,
  parameter int unsigned OUT_DEPTH_LOG2 = DEF_OUT_DEPTH_LOG2
) (
  input  logic                              clk,
  input  logic                              rst,
  accel_stream_if.slave                     toaccel,
  output logic [PTR_W-1:0]                  toaccel_rdptr,
  accel_stream_if.master                    core_in,
  accel_stream_if.slave                     core_out,
  accel_stream_if.master                    fromaccel,
  output logic [PTR_W-1:0]                  fromaccel_wrptr,
  output logic [occ_w(IN_DEPTH_LOG2)-1:0]   in_level
);

  localparam int unsigned OUT_LW = occ_w(OUT_DEPTH_LOG2);
  localparam int unsigned IN_LW  = occ_w(IN_DEPTH_LOG2);

  logic [OUT_LW-1:0] out_level;

  stream_fifo #(.DW(DW), .DEPTH_LOG2(IN_DEPTH_LOG2)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (toaccel.data),
    .in_valid  (toaccel.valid),
    .in_ready  (toaccel.ready),
    .out_data  (core_in.data),
    .out_valid (core_in.valid),
    .out_ready (core_in.ready),
    .level     (in_level)
  );

  stream_fifo #(.DW(DW), .DEPTH_LOG2(OUT_DEPTH_LOG2)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (core_out.data),
    .in_valid  (core_out.valid),
    .in_ready  (core_out.ready),
    .out_data  (fromaccel.data),
    .out_valid (fromaccel.valid),
    .out_ready (fromaccel.ready),
    .level     (out_level)
  );

  // Progress counters wrap at 2^PTR_W, independent of the FIFO storage index.
  always_ff @(posedge clk) begin
    if (rst) begin
      toaccel_rdptr   <= '0;
      fromaccel_wrptr <= '0;
    end else begin
      if (core_in.valid && core_in.ready) begin
        toaccel_rdptr <= toaccel_rdptr + PTR_W'(1);
      end
      if (core_out.valid && core_out.ready) begin
        fromaccel_wrptr <= fromaccel_wrptr + PTR_W'(1);
      end
    end
  end

  a_in_level_bound : assert property (@(posedge clk) disable iff (rst)
    in_level <= IN_LW'(32'd1 << IN_DEPTH_LOG2));
  a_out_level_bound : assert property (@(posedge clk) disable iff (rst)
    out_level <= OUT_LW'(32'd1 << OUT_DEPTH_LOG2));

endmodule

// File: tb/tb_accel_stream_endpoint.sv
// Scoreboard bench for accel_stream_endpoint: queue-based reference model with
// one-cycle visibility timestamps, driven by directed and randomized traffic.
module tb_accel_stream_endpoint;

  localparam int IN_DEPTH  = 512;
  localparam int OUT_DEPTH = 16;
  localparam int PTR_MOD   = 1024;

  logic clk = 1'b0;
  logic rst;

  accel_stream_if #(.DW(128)) toaccel   ();
  accel_stream_if #(.DW(128)) core_in   ();
  accel_stream_if #(.DW(128)) core_out  ();
  accel_stream_if #(.DW(128)) fromaccel ();

  logic [9:0] toaccel_rdptr;
  logic [9:0] fromaccel_wrptr;
  logic [9:0] in_level;

  accel_stream_endpoint dut (
    .clk             (clk),
    .rst             (rst),
    .toaccel         (toaccel),
    .toaccel_rdptr   (toaccel_rdptr),
    .core_in         (core_in),
    .core_out        (core_out),
    .fromaccel       (fromaccel),
    .fromaccel_wrptr (fromaccel_wrptr),
    .in_level        (in_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic [127:0] data;
    int           edge_no;
  } ent_t;

  ent_t in_q[$];
  ent_t out_q[$];
  int   cur_edge = 0;
  int   in_lvl   = 0;
  int   out_lvl  = 0;
  int   rd_cnt   = 0;
  int   wr_cnt   = 0;
  bit   last_rst = 1'b1;

  // Sampled mid-cycle: checks the state left by the last edge, then records the
  // transfers that the coming edge will perform.
  always @(negedge clk) begin
    bit in_v_exp;
    bit out_v_exp;
    cur_edge++;
    // A word is visible one edge after the edge that accepted it.
    in_v_exp  = (in_q.size()  > 0) && (in_q[0].edge_no  <= cur_edge - 1);
    out_v_exp = (out_q.size() > 0) && (out_q[0].edge_no <= cur_edge - 1);
    if (last_rst) begin
      chk("rst_toaccel_tready",   toaccel.ready,   '0);
      chk("rst_core_in_valid",    core_in.valid,   '0);
      chk("rst_core_out_ready",   core_out.ready,  '0);
      chk("rst_fromaccel_tvalid", fromaccel.valid, '0);
      chk("rst_rdptr",            toaccel_rdptr,   '0);
      chk("rst_wrptr",            fromaccel_wrptr, '0);
      chk("rst_in_level",         in_level,        '0);
    end else begin
      chk("toaccel_tready", toaccel.ready, 128'(in_lvl != IN_DEPTH));
      chk("core_in_valid",  core_in.valid, 128'(in_v_exp));
      if (in_v_exp && core_in.valid === 1'b1) chk("core_in_data", core_in.data, in_q[0].data);
      chk("toaccel_rdptr",  toaccel_rdptr, 128'(rd_cnt));
      chk("in_level",       in_level,      128'(in_lvl));
      chk("core_out_ready", core_out.ready, 128'(out_lvl != OUT_DEPTH));
      chk("fromaccel_tvalid", fromaccel.valid, 128'(out_v_exp));
      if (out_v_exp && fromaccel.valid === 1'b1) chk("fromaccel_tdata", fromaccel.data, out_q[0].data);
      chk("fromaccel_wrptr", fromaccel_wrptr, 128'(wr_cnt));
    end
    if (rst) begin
      in_q.delete();
      out_q.delete();
      in_lvl  = 0;
      out_lvl = 0;
      rd_cnt  = 0;
      wr_cnt  = 0;
    end else begin
      if (toaccel.valid && toaccel.ready) begin
        in_q.push_back('{toaccel.data, cur_edge + 1});
        in_lvl++;
      end
      if (core_in.valid && core_in.ready) begin
        if (in_v_exp) void'(in_q.pop_front());
        in_lvl--;
        rd_cnt = (rd_cnt + 1) % PTR_MOD;
      end
      if (core_out.valid && core_out.ready) begin
        out_q.push_back('{core_out.data, cur_edge + 1});
        out_lvl++;
        wr_cnt = (wr_cnt + 1) % PTR_MOD;
      end
      if (fromaccel.valid && fromaccel.ready) begin
        if (out_v_exp) void'(out_q.pop_front());
        out_lvl--;
      end
    end
    last_rst = rst;
  end

  // ---------------- stimulus ----------------
  int in_word  = 0;
  int in_pops  = 0;
  int out_pops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rand_cycle(input int pv_in, input int pr_core, input int pv_out,
                            input int pr_from, input bit in_en);
    bit in_acc;
    bit out_acc;
    toaccel.valid   = in_en && ($urandom_range(0, 99) < pv_in);
    toaccel.data    = 128'(in_word);
    core_in.ready   = ($urandom_range(0, 99) < pr_core);
    core_out.valid  = ($urandom_range(0, 99) < pv_out);
    fromaccel.ready = ($urandom_range(0, 99) < pr_from);
    in_acc  = toaccel.valid && toaccel.ready;
    out_acc = core_out.valid && core_out.ready;
    if (core_in.valid && core_in.ready) in_pops++;
    if (fromaccel.valid && fromaccel.ready) out_pops++;
    tick();
    if (in_acc) in_word++;
    if (out_acc) core_out.data = rand128();
  endtask

  task automatic idle_inputs();
    toaccel.valid   = 1'b0;
    core_in.ready   = 1'b0;
    core_out.valid  = 1'b0;
    fromaccel.ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;
    bit acc;

    rst = 1'b1;
    toaccel.data  = '0;
    core_out.data = '0;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;

    // Single beat after reset.
    tick();
    chk("first_cycle_tready", toaccel.ready, 1);
    chk("first_cycle_core_out_ready", core_out.ready, 1);
    repeat (5) tick();
    toaccel.data  = {16{8'hA5}};
    toaccel.valid = 1'b1;
    tick();
    toaccel.valid = 1'b0;
    chk("single_valid_not_yet", core_in.valid, 0);
    tick();
    chk("single_valid", core_in.valid, 1);
    chk("single_data", core_in.data, {16{8'hA5}});
    chk("single_level", in_level, 1);
    chk("single_rdptr0", toaccel_rdptr, 0);
    core_in.ready = 1'b1;
    tick();
    core_in.ready = 1'b0;
    chk("single_rdptr1", toaccel_rdptr, 1);
    chk("single_valid_gone", core_in.valid, 0);

    // Fill the inbound FIFO to capacity.
    in_word = 1000;
    toaccel.valid = 1'b1;
    cnt = 0;
    guard = 0;
    while (cnt < IN_DEPTH && guard < 2000) begin
      toaccel.data = 128'(in_word);
      acc = toaccel.ready;
      tick();
      if (acc) begin cnt++; in_word++; end
      guard++;
    end
    chk("fill_accepted", cnt, IN_DEPTH);
    toaccel.data = 128'(in_word);
    chk("full_tready", toaccel.ready, 0);
    chk("full_level", in_level, IN_DEPTH);
    repeat (4) tick();
    chk("full_hold_tready", toaccel.ready, 0);
    chk("full_hold_level", in_level, IN_DEPTH);
    core_in.ready = 1'b1;
    tick();
    core_in.ready = 1'b0;
    chk("after_pop_tready", toaccel.ready, 1);
    tick();
    toaccel.valid = 1'b0;
    in_word++;
    chk("refill_level", in_level, IN_DEPTH);
    core_in.ready = 1'b1;
    repeat (IN_DEPTH + 8) tick();
    core_in.ready = 1'b0;
    chk("fill_drained", in_level, 0);

    // Pointer wrap: 1030 incrementing words with random backpressure.
    do_reset(2);
    tick();
    in_word = 0;
    guard = 0;
    while (in_word < 1030 && guard < 8000) begin
      rand_cycle(80, 60, 0, 100, 1'b1);
      guard++;
    end
    chk("wrap_sent", in_word, 1030);
    idle_inputs();
    core_in.ready = 1'b1;
    repeat (IN_DEPTH + 8) tick();
    core_in.ready = 1'b0;
    chk("wrap_rdptr", toaccel_rdptr, 6);
    chk("wrap_level", in_level, 0);

    // Outbound backpressure.
    fromaccel.ready = 1'b0;
    core_out.valid  = 1'b1;
    cnt = 0;
    guard = 0;
    while (cnt < OUT_DEPTH && guard < 100) begin
      core_out.data = rand128();
      acc = core_out.ready;
      tick();
      if (acc) cnt++;
      guard++;
    end
    core_out.data = rand128();
    chk("out_fill", cnt, OUT_DEPTH);
    chk("out_full_ready", core_out.ready, 0);
    chk("out_full_wrptr", fromaccel_wrptr, 16);
    repeat (3) tick();
    chk("out_hold_wrptr", fromaccel_wrptr, 16);
    core_out.valid  = 1'b0;
    fromaccel.ready = 1'b1;
    cnt = 0;
    repeat (25) begin
      if (fromaccel.valid && fromaccel.ready) cnt++;
      tick();
    end
    fromaccel.ready = 1'b0;
    chk("out_drained_beats", cnt, 16);
    chk("out_drained_valid", fromaccel.valid, 0);

    // Simultaneous push and pop at occupancy one.
    toaccel.data  = 128'hCAFE;
    toaccel.valid = 1'b1;
    tick();
    toaccel.valid = 1'b0;
    tick();
    toaccel.data  = 128'hBEEF;
    toaccel.valid = 1'b1;
    core_in.ready = 1'b1;
    tick();
    toaccel.valid = 1'b0;
    core_in.ready = 1'b0;
    chk("occ1_level", in_level, 1);
    tick();
    chk("occ1_valid", core_in.valid, 1);
    chk("occ1_data", core_in.data, 128'hBEEF);
    core_in.ready = 1'b1;
    tick();
    core_in.ready = 1'b0;

    // Both directions at full rate.
    in_pops  = 0;
    out_pops = 0;
    cnt = in_word;
    repeat (200) rand_cycle(100, 100, 100, 100, 1'b1);
    chk("rate_in_accepts", in_word - cnt, 200);
    chk("rate_in_pops_ok", 128'(in_pops >= 198), 1);
    chk("rate_out_pops_ok", 128'(out_pops >= 198), 1);
    idle_inputs();
    core_in.ready   = 1'b1;
    fromaccel.ready = 1'b1;
    repeat (10) tick();
    idle_inputs();

    // Reset with words buffered in both directions.
    toaccel.valid  = 1'b1;
    core_out.valid = 1'b1;
    repeat (5) begin
      toaccel.data  = rand128();
      core_out.data = rand128();
      tick();
    end
    idle_inputs();
    tick();
    chk("pre_rst_level", in_level, 5);
    rst = 1'b1;
    tick();
    chk("mid_rst_core_in_valid", core_in.valid, 0);
    chk("mid_rst_fromaccel_valid", fromaccel.valid, 0);
    chk("mid_rst_level", in_level, 0);
    chk("mid_rst_wrptr", fromaccel_wrptr, 0);
    rst = 1'b0;
    core_in.ready   = 1'b1;
    fromaccel.ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (core_in.valid || fromaccel.valid) cnt++;
    end
    chk("no_stale_words", cnt, 0);
    idle_inputs();

    // Random mixed traffic on both paths.
    repeat (800) rand_cycle($urandom_range(30, 95), $urandom_range(30, 95),
                            $urandom_range(30, 95), $urandom_range(30, 95), 1'b1);
    idle_inputs();
    core_in.ready   = 1'b1;
    fromaccel.ready = 1'b1;
    repeat (IN_DEPTH + 8) tick();
    chk("final_level", in_level, 0);
    chk("final_out_valid", fromaccel.valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/accel_stream_endpoint.md
Name: accel_stream_endpoint

Overview:
Accelerator-side terminus of the toaccel/fromaccel AXI-Stream pair driven by axi4_controller. It receives 128-bit toaccel beats into an inbound FIFO and presents them to the accelerator core. It buffers core results in an outbound FIFO and transmits them as fromaccel beats. It exports the 10-bit rdptr/wrptr progress counters the controller uses for host-side flow control.

Parameters:
DW, 128, stream data width.
PTR_W, 10, width of exported progress counters; they wrap modulo 2^PTR_W.
IN_DEPTH_LOG2, 9, log2 inbound FIFO depth (512 words); must be < PTR_W.
OUT_DEPTH_LOG2, 4, log2 outbound FIFO depth (16 words); must be < PTR_W.

Ports:
clk  in  1  single clock domain.
rst  in  1  synchronous, active-high reset.
toaccel_tdata  in  DW  inbound beat data from controller.
toaccel_tvalid  in  1  inbound beat valid.
toaccel_tready  out  1  inbound FIFO can accept.
toaccel_rdptr  out  PTR_W  count of words consumed by the core, mod 2^PTR_W.
core_in_data  out  DW  head of inbound FIFO.
core_in_valid  out  1  inbound FIFO non-empty.
core_in_ready  in  1  core consumes head.
core_out_data  in  DW  result word from core.
core_out_valid  in  1  result valid.
core_out_ready  out  1  outbound FIFO can accept.
fromaccel_tdata  out  DW  outbound beat data to controller.
fromaccel_tvalid  out  1  outbound FIFO non-empty.
fromaccel_tready  in  1  controller accepts beat.
fromaccel_wrptr  out  PTR_W  count of words pushed by the core, mod 2^PTR_W.
in_level  out  IN_DEPTH_LOG2+1  inbound occupancy, 0..2^IN_DEPTH_LOG2.

Behaviour:
- Reset (rst high at a clk edge): all FIFO pointers and occupancies cleared. Buffered data is discarded. Reset values: toaccel_tready=0, core_in_valid=0, core_out_ready=0, fromaccel_tvalid=0, toaccel_rdptr=0, fromaccel_wrptr=0, in_level=0. Data outputs are don't-care while their valid is 0.
- First cycle after rst deasserts: toaccel_tready=1 and core_out_ready=1.
- Handshake: a transfer occurs on an edge where valid&&ready. Valid outputs never depend combinationally on the matching ready. tready and core_out_ready are registered, derived from occupancy.
- Inbound FIFO:
  - Push on toaccel_tvalid&&toaccel_tready.
  - Pop on core_in_valid&&core_in_ready.
  - toaccel_tready=0 exactly when occupancy==2^IN_DEPTH_LOG2. A simultaneous push and pop when full is not possible, because tready is already 0.
  - Simultaneous push and pop when non-full and non-empty: occupancy unchanged, both succeed.
- Inbound latency: a word pushed at edge N into an empty FIFO shows core_in_valid=1 and core_in_data=word after edge N+1 (one cycle). Memory uses a registered read plus a first-word-fall-through output register. The output register counts in occupancy.
- Ordering: strict FIFO order; no word lost or duplicated across pointer wrap.
- toaccel_rdptr increments by 1 on each inbound pop and wraps 2^PTR_W-1 -> 0.
- Outbound FIFO: identical structure. Push on core_out_valid&&core_out_ready; pop on fromaccel_tvalid&&fromaccel_tready. Same one-cycle latency.
- fromaccel_wrptr increments by 1 on each outbound push and wraps identically.
- Internal address pointers carry one extra wrap bit to distinguish full from empty. Storage index wraps at the depth independently of the PTR_W counters.
- No state machine beyond the FIFOs. Inbound and outbound paths are fully independent; stalls on one never block the other.

Decomposition:
- Shared package accel_stream_pkg: DW and PTR_W defaults, and the occupancy-width helper function.
- One sub-module, stream_fifo (parameters DW, DEPTH_LOG2): FWFT synchronous FIFO with valid/ready on both sides and an occupancy output. Instantiated twice.
- Top level adds the rdptr/wrptr counters and the port mapping.

Test Plan:
- Reset then single beat: push 0xA5..A5 at cycle 10 with core_in_ready=0 -> core_in_valid=1 from cycle 11 with data 0xA5..A5; in_level=1; rdptr=0. Set core_in_ready=1 -> rdptr=1, core_in_valid=0 next cycle.
- Fill inbound: 512 beats with tvalid held high and core_in_ready=0 -> toaccel_tready drops after the 512th acceptance; in_level=512; a 513th beat is held, not accepted. One pop -> tready returns and the 513th word is accepted.
- Wrap: stream 1030 incrementing words with random core_in_ready -> core sees 0..1029 in order; toaccel_rdptr ends at 6.
- Outbound backpressure: core pushes 16 words with fromaccel_tready=0 -> core_out_ready=0 after 16; fromaccel_wrptr=16. Release -> 16 beats out in order.
- Concurrent paths: inbound and outbound at full rate, plus simultaneous push/pop at occupancy 1 -> occupancy stays 1; throughput of one word per cycle each way.
- Reset mid-stream: assert rst with 5 words buffered -> next cycle all valids 0, counters 0, in_level 0; no stale word appears afterwards.
